// File: rtl/loteria_if.sv
// Bus between the lottery checker and its host: strobes and number in, results out.
interface loteria_if #(
    parameter int unsigned NUM_W = 4,
    parameter int unsigned PICKS = 5,
    parameter int unsigned CNT_W = 5
);
    localparam int unsigned ACC_W = $clog2(PICKS + 1);

    logic [NUM_W-1:0] numero;
    logic             insere;
    logic             fim_jogo;
    logic             fim;
    logic [1:0]       premio;
    logic [CNT_W-1:0] p1;
    logic [CNT_W-1:0] p2;
    logic [ACC_W-1:0] acertos;
    logic             valido;
    logic             erro;
    logic             sorteado;
    logic             encerrado;

    modport master (
        output numero, insere, fim_jogo, fim,
        input  premio, p1, p2, acertos, valido, erro, sorteado, encerrado
    );

    modport slave (
        input  numero, insere, fim_jogo, fim,
        output premio, p1, p2, acertos, valido, erro, sorteado, encerrado
    );
endinterface

// File: rtl/loteria_param.sv
// Lottery checker: loads a draw set, then scores tickets against it and counts prizes.
// Sets are held as bitmaps indexed by number, so duplicate checks and matching are bitwise.
module loteria_param #(
    parameter int unsigned NUM_W   = 4,
    parameter int unsigned MAX_NUM = 15,
    parameter int unsigned PICKS   = 5,
    parameter int unsigned CNT_W   = 5
) (
    input  logic     clock,
    input  logic     reset,
    loteria_if.slave bus
);
    localparam int unsigned ACC_W = $clog2(PICKS + 1);
    localparam int unsigned SET_N = MAX_NUM + 1;

    typedef enum logic [1:0] {SORTEIO, JOGO, AVALIA, FIM} state_e;

    state_e           state_q, state_d;
    logic [SET_N-1:0] draw_q, draw_d, tkt_q, tkt_d;
    logic [ACC_W-1:0] draw_n_q, draw_n_d, tkt_n_q, tkt_n_d;
    logic [ACC_W-1:0] acertos_q, acertos_d;
    logic [1:0]       premio_q, premio_d;
    logic [CNT_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic             valido_q, valido_d, erro_q, erro_d;
    logic             sorteado_q, sorteado_d, encerrado_q, encerrado_d;

    logic [SET_N-1:0] num_oh_c;
    logic             legal_c, in_draw_c, in_tkt_c, ins_c, draw_last_c;
    logic [ACC_W-1:0] match_c;

    // Simultaneous insere and fim_jogo is treated as fim_jogo alone.
    assign ins_c       = bus.insere & ~bus.fim_jogo;
    assign legal_c     = (bus.numero != '0) && (32'(bus.numero) <= MAX_NUM);
    assign num_oh_c    = SET_N'(1) << bus.numero;
    assign in_draw_c   = |(draw_q & num_oh_c);
    assign in_tkt_c    = |(tkt_q & num_oh_c);
    assign draw_last_c = (draw_n_q == ACC_W'(PICKS - 1));

    always_comb begin
        match_c = '0;
        for (int unsigned i = 0; i < SET_N; i++) begin
            match_c = match_c + ACC_W'(draw_q[i] & tkt_q[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= SORTEIO;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SORTEIO: if (ins_c && legal_c && !in_draw_c && draw_last_c) state_d = JOGO;
            JOGO: begin
                if (bus.fim)                                           state_d = FIM;
                else if (bus.fim_jogo && tkt_n_q == ACC_W'(PICKS))     state_d = AVALIA;
            end
            AVALIA:  state_d = bus.fim ? FIM : JOGO;
            FIM:     state_d = FIM;
            default: state_d = SORTEIO;
        endcase
    end

    always_comb begin
        draw_d      = draw_q;
        draw_n_d    = draw_n_q;
        tkt_d       = tkt_q;
        tkt_n_d     = tkt_n_q;
        acertos_d   = acertos_q;
        premio_d    = premio_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        valido_d    = 1'b0;
        erro_d      = 1'b0;
        sorteado_d  = (state_d != SORTEIO);
        encerrado_d = (state_d == FIM);
        case (state_q)
            SORTEIO: begin
                if (bus.fim_jogo) begin
                    erro_d = 1'b1;
                end else if (ins_c) begin
                    if (legal_c && !in_draw_c) begin
                        draw_d   = draw_q | num_oh_c;
                        draw_n_d = draw_n_q + ACC_W'(1);
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            JOGO: begin
                if (bus.fim) begin
                    tkt_d   = '0;
                    tkt_n_d = '0;
                end else if (bus.fim_jogo) begin
                    // A short ticket is thrown away; a full one is kept for AVALIA.
                    if (tkt_n_q != ACC_W'(PICKS)) begin
                        erro_d  = 1'b1;
                        tkt_d   = '0;
                        tkt_n_d = '0;
                    end
                end else if (ins_c) begin
                    if (legal_c && !in_tkt_c && tkt_n_q < ACC_W'(PICKS)) begin
                        tkt_d   = tkt_q | num_oh_c;
                        tkt_n_d = tkt_n_q + ACC_W'(1);
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            AVALIA: begin
                acertos_d = match_c;
                valido_d  = 1'b1;
                tkt_d     = '0;
                tkt_n_d   = '0;
                erro_d    = bus.insere | bus.fim_jogo;
                if (match_c == ACC_W'(PICKS)) begin
                    premio_d = 2'b01;
                    if (p1_q != '1) p1_d = p1_q + CNT_W'(1);
                end else if (match_c == ACC_W'(PICKS - 1)) begin
                    premio_d = 2'b10;
                    if (p2_q != '1) p2_d = p2_q + CNT_W'(1);
                end else begin
                    premio_d = 2'b00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            draw_q      <= '0;
            draw_n_q    <= '0;
            tkt_q       <= '0;
            tkt_n_q     <= '0;
            acertos_q   <= '0;
            premio_q    <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            valido_q    <= 1'b0;
            erro_q      <= 1'b0;
            sorteado_q  <= 1'b0;
            encerrado_q <= 1'b0;
        end else begin
            draw_q      <= draw_d;
            draw_n_q    <= draw_n_d;
            tkt_q       <= tkt_d;
            tkt_n_q     <= tkt_n_d;
            acertos_q   <= acertos_d;
            premio_q    <= premio_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            valido_q    <= valido_d;
            erro_q      <= erro_d;
            sorteado_q  <= sorteado_d;
            encerrado_q <= encerrado_d;
        end
    end

    assign bus.premio    = premio_q;
    assign bus.acertos   = acertos_q;
    assign bus.p1        = p1_q;
    assign bus.p2        = p2_q;
    assign bus.valido    = valido_q;
    assign bus.erro      = erro_q;
    assign bus.sorteado  = sorteado_q;
    assign bus.encerrado = encerrado_q;
endmodule

// File: tb/tb_loteria_param.sv
// Bench for loteria_param: queue-based reference model checked every cycle plus hand-computed pins.
module tb_loteria_param;
    localparam int NUM_W = 4;
    localparam int MAXN  = 15;
    localparam int PICKS = 5;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    loteria_if #(.NUM_W(NUM_W), .PICKS(PICKS), .CNT_W(CNT_W)) bus ();

    loteria_param #(.NUM_W(NUM_W), .MAX_NUM(MAXN), .PICKS(PICKS), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 drawing, 1 playing, 2 ticket under evaluation, 3 closed.
    int draw[$];
    int tkt[$];
    int phase = 0;
    int e_premio = 0, e_acertos = 0, e_p1 = 0, e_p2 = 0;
    bit e_valido = 0, e_erro = 0;

    function automatic bit has(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clock or posedge reset) begin
        int n;
        int hits;
        bit ins;
        if (reset) begin
            draw.delete(); tkt.delete(); phase = 0;
            e_premio = 0; e_acertos = 0; e_p1 = 0; e_p2 = 0; e_valido = 0; e_erro = 0;
        end else begin
            n = int'(bus.numero);
            ins = bus.insere && !bus.fim_jogo;
            e_valido = 0;
            e_erro = 0;
            if (phase == 0) begin
                if (bus.fim_jogo) e_erro = 1;
                else if (ins) begin
                    if (n >= 1 && n <= MAXN && !has(draw, n)) begin
                        draw.push_back(n);
                        if (draw.size() == PICKS) phase = 1;
                    end else e_erro = 1;
                end
            end else if (phase == 1) begin
                if (bus.fim) begin
                    tkt.delete(); phase = 3;
                end else if (bus.fim_jogo) begin
                    if (tkt.size() == PICKS) phase = 2;
                    else begin e_erro = 1; tkt.delete(); end
                end else if (ins) begin
                    if (n >= 1 && n <= MAXN && !has(tkt, n) && tkt.size() < PICKS) tkt.push_back(n);
                    else e_erro = 1;
                end
            end else if (phase == 2) begin
                hits = 0;
                foreach (tkt[i]) if (has(draw, tkt[i])) hits++;
                e_acertos = hits;
                e_valido = 1;
                e_premio = (hits == PICKS) ? 1 : (hits == PICKS - 1) ? 2 : 0;
                if (e_premio == 1 && e_p1 < CMAX) e_p1++;
                if (e_premio == 2 && e_p2 < CMAX) e_p2++;
                e_erro = bus.insere || bus.fim_jogo;
                tkt.delete();
                phase = bus.fim ? 3 : 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        chk("premio",    int'(bus.premio),    e_premio);
        chk("acertos",   int'(bus.acertos),   e_acertos);
        chk("p1",        int'(bus.p1),        e_p1);
        chk("p2",        int'(bus.p2),        e_p2);
        chk("valido",    int'(bus.valido),    int'(e_valido));
        chk("erro",      int'(bus.erro),      int'(e_erro));
        chk("sorteado",  int'(bus.sorteado),  int'(phase != 0));
        chk("encerrado", int'(bus.encerrado), int'(phase == 3));
    end

    task automatic cyc(input int n, input bit ins, input bit fj, input bit f);
        @(negedge clock);
        bus.numero = NUM_W'(n); bus.insere = ins; bus.fim_jogo = fj; bus.fim = f;
        @(posedge clock);
        #1;
        bus.insere = 1'b0; bus.fim_jogo = 1'b0; bus.fim = 1'b0;
    endtask

    task automatic put5(input int v[5]);
        for (int i = 0; i < 5; i++) cyc(v[i], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic play(input int v[5]);
        put5(v);
        cyc(0, 1'b0, 1'b1, 1'b0);
        chk("lat_valido_k", int'(bus.valido), 0);
        cyc(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.numero = '0; bus.insere = 1'b0; bus.fim_jogo = 1'b0; bus.fim = 1'b0;
        do_reset();
        chk("rst_p1", int'(bus.p1), 0);
        chk("rst_sorteado", int'(bus.sorteado), 0);

        // Draw with rejections mixed in.
        cyc(3, 1, 0, 0);
        cyc(3, 1, 0, 0); chk("draw_dup_erro", int'(bus.erro), 1);
        cyc(0, 1, 0, 0); chk("draw_zero_erro", int'(bus.erro), 1);
        cyc(0, 0, 1, 0); chk("draw_fj_erro", int'(bus.erro), 1);
        cyc(8, 1, 0, 0); cyc(6, 1, 0, 0); cyc(9, 1, 0, 0);
        chk("draw_not_done", int'(bus.sorteado), 0);
        cyc(1, 1, 0, 0); chk("draw_done", int'(bus.sorteado), 1);

        play('{1, 2, 3, 4, 5});
        chk("t1_acertos", int'(bus.acertos), 2);
        chk("t1_premio", int'(bus.premio), 0);
        chk("t1_valido", int'(bus.valido), 1);
        play('{3, 8, 6, 9, 1});
        chk("t2_premio", int'(bus.premio), 1);
        chk("t2_acertos", int'(bus.acertos), 5);
        chk("t2_p1", int'(bus.p1), 1);
        play('{3, 8, 6, 2, 1});
        chk("t3_premio", int'(bus.premio), 2);
        chk("t3_acertos", int'(bus.acertos), 4);
        chk("t3_p2", int'(bus.p2), 1);
        chk("t3_p1", int'(bus.p1), 1);

        // Ticket rejections and a short fim_jogo.
        cyc(3, 1, 0, 0);
        cyc(3, 1, 0, 0); chk("tkt_dup_erro", int'(bus.erro), 1);
        cyc(0, 1, 0, 0); chk("tkt_zero_erro", int'(bus.erro), 1);
        cyc(8, 1, 0, 0); cyc(6, 1, 0, 0); cyc(9, 1, 0, 0);
        cyc(0, 0, 1, 0); chk("short_erro", int'(bus.erro), 1);
        cyc(0, 0, 0, 0);
        chk("short_valido", int'(bus.valido), 0);
        chk("short_premio", int'(bus.premio), 2);

        // Full ticket overflow, then insere+fim_jogo together evaluates without erro.
        put5('{3, 8, 6, 9, 1});
        cyc(2, 1, 0, 0); chk("full_erro", int'(bus.erro), 1);
        cyc(7, 1, 1, 0); chk("both_no_erro", int'(bus.erro), 0);
        cyc(0, 0, 0, 0); chk("sat_p1_2", int'(bus.p1), 2);
        play('{1, 9, 6, 8, 3}); chk("sat_p1_3", int'(bus.p1), 3);
        play('{9, 1, 3, 6, 8}); chk("sat_p1_3b", int'(bus.p1), 3);
        play('{8, 3, 1, 9, 6}); chk("sat_p1_3c", int'(bus.p1), 3);

        // Reset while a ticket is under evaluation.
        put5('{3, 8, 6, 9, 1});
        cyc(0, 0, 1, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_valido", int'(bus.valido), 0);
        chk("abort_p1", int'(bus.p1), 0);
        chk("abort_sorteado", int'(bus.sorteado), 0);
        chk("abort_encerrado", int'(bus.encerrado), 0);
        @(negedge clock); reset = 1'b0;
        put5('{3, 8, 6, 9, 1});
        chk("reload_sorteado", int'(bus.sorteado), 1);

        // fim during evaluation still scores the ticket, then everything freezes.
        put5('{3, 8, 6, 9, 4});
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        chk("fim_eval_valido", int'(bus.valido), 1);
        chk("fim_eval_premio", int'(bus.premio), 2);
        chk("fim_encerrado", int'(bus.encerrado), 1);
        cyc(5, 1, 0, 0); chk("fim_ins_erro", int'(bus.erro), 0);
        cyc(0, 0, 1, 0); chk("fim_fj_erro", int'(bus.erro), 0);
        cyc(0, 0, 0, 0);
        chk("fim_frozen_p2", int'(bus.p2), 1);
        chk("fim_frozen_valido", int'(bus.valido), 0);

        // fim together with fim_jogo discards a full ticket.
        do_reset();
        put5('{3, 8, 6, 9, 1});
        put5('{3, 8, 6, 9, 1});
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        chk("fimfj_valido", int'(bus.valido), 0);
        chk("fimfj_p1", int'(bus.p1), 0);
        chk("fimfj_encerrado", int'(bus.encerrado), 1);
        cyc(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/loteria_param.md
LOTERIA_PARAM -- requirements
Module: loteria_param

Interface
REQ-001 Parameter NUM_W, default 4, bit width of a lottery number.
REQ-002 Parameter MAX_NUM, default 15, largest legal number; legal range is 1..MAX_NUM.
REQ-003 Parameter PICKS, default 5, numbers per draw and per ticket (PICKS >= 2).
REQ-004 Parameter CNT_W, default 5, width of the prize counters p1/p2.
REQ-005 clock  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 numero  in  NUM_W  number presented with insere.
REQ-008 insere  in  1  one-cycle strobe: accept numero into the draw set or the current ticket.
REQ-009 fim_jogo  in  1  one-cycle strobe: close the current ticket and evaluate it.
REQ-010 fim  in  1  one-cycle strobe: close the session.
REQ-011 premio  out  2  result of last evaluated ticket: 00 none, 01 prize 1, 10 prize 2; 11 never driven.
REQ-012 p1  out  CNT_W  count of prize-1 tickets this session.
REQ-013 p2  out  CNT_W  count of prize-2 tickets this session.
REQ-014 acertos  out  clog2(PICKS+1)  match count of the last evaluated ticket.
REQ-015 valido  out  1  one-cycle pulse: premio/acertos just updated.
REQ-016 erro  out  1  one-cycle pulse: last strobe rejected.
REQ-017 sorteado  out  1  high while the draw set is complete (states JOGO, AVALIA, FIM).
REQ-018 encerrado  out  1  high in state FIM.

Function
REQ-019 The FSM SHALL have states SORTEIO, JOGO, AVALIA, FIM; SORTEIO is entered on reset.
REQ-020 In SORTEIO, each insere with a legal, non-duplicate numero SHALL store it in the draw set; after the PICKS-th accept the FSM SHALL enter JOGO on the same edge.
REQ-021 In JOGO, each insere with a legal, non-duplicate numero SHALL store it in the ticket while the ticket holds fewer than PICKS numbers.
REQ-022 A rejected insere (numero 0, numero > MAX_NUM, duplicate within the set being filled, or ticket already full) SHALL pulse erro the next cycle and change no stored state.
REQ-023 fim_jogo in JOGO with exactly PICKS numbers held SHALL move the FSM to AVALIA.
REQ-024 fim_jogo in JOGO with fewer than PICKS numbers SHALL pulse erro, clear the ticket, and leave premio, acertos and counters unchanged.
REQ-025 In AVALIA (one cycle), acertos SHALL equal the number of ticket entries present in the draw set, and the FSM SHALL return to JOGO with the ticket cleared.
REQ-026 premio SHALL be 01 if acertos == PICKS, 10 if acertos == PICKS-1, else 00; valido SHALL pulse on the same edge.
REQ-027 Latency: fim_jogo sampled at edge k SHALL produce premio/acertos/valido at edge k+1, and p1/p2 SHALL be updated at edge k+1.
REQ-028 p1 increments on premio 01 and p2 on premio 10; both SHALL saturate at 2^CNT_W-1.
REQ-029 premio and acertos SHALL hold until the next evaluation or reset.
REQ-030 insere or fim_jogo received in SORTEIO (fim_jogo) or AVALIA (either) SHALL be ignored with an erro pulse.
REQ-031 insere and fim_jogo asserted together SHALL be treated as fim_jogo only; insere is dropped without erro.
REQ-032 fim in JOGO or AVALIA SHALL enter FIM; an AVALIA in progress SHALL still complete its evaluation; a partial ticket SHALL be discarded.
REQ-033 fim together with fim_jogo SHALL take priority; the ticket SHALL be discarded unevaluated.
REQ-034 In FIM, all strobes SHALL be ignored without erro and all outputs held; only reset exits FIM.

Reset
REQ-035 While reset is high: state SORTEIO, draw set and ticket empty, premio=00, p1=p2=0, acertos=0, valido=erro=sorteado=encerrado=0.
REQ-036 reset asserted in any state, including mid-AVALIA, SHALL abort immediately with no valido pulse and no counter update.

Verification
REQ-037 Draw 3,8,6,9,1; ticket 1,2,3,4,5 + fim_jogo -> edge k+1: acertos=2, premio=00, valido=1, p1=p2=0.
REQ-038 Same draw; ticket 3,8,6,9,1 -> premio=01, acertos=5, p1=1; then ticket 3,8,6,2,1 -> premio=10, acertos=4, p2=1, p1 stays 1.
REQ-039 Ticket inserts 3,3 -> erro pulse, ticket holds 1 number; numero=0 -> erro; fim_jogo after 4 numbers -> erro, no valido, premio unchanged.
REQ-040 CNT_W=2: five prize-1 tickets -> p1 = 1,2,3,3,3.
REQ-041 fim, then insere/fim_jogo -> encerrado=1, no erro, outputs frozen; fim with fim_jogo on a full ticket -> no valido.
REQ-042 reset asserted during AVALIA -> all outputs zero, sorteado=0, FIM not entered; draw reload required.
